fp_wb_scoreboard_arbiter: RTL and testbench

// - Sequences the single write port of the FP register file (32x32b, doubles use pair rd/rd+1).
// - Round-robin arbitrates up to NUM_REQ FP result sources (single ALU, double unit, FP load) onto it.
// - Keeps a 32-bit busy scoreboard: issue reserves destinations, writeback releases them, RS/RT hazard flags feed the stall logic.

---
 rtl/fp_wb_scoreboard_arbiter_if.sv | 39 +++
 rtl/fp_wb_scoreboard_arbiter.sv | 133 +++++++++++++
 tb/tb_fp_wb_scoreboard_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_wb_scoreboard_arbiter_if.sv
// Issue, hazard-check and writeback bus between the FP pipeline and the FP write-port sequencer.
interface fp_wb_scoreboard_arbiter_if #(parameter int unsigned NUM_REQ = 3);
   logic                     iss_valid_i;
   logic [4:0]               iss_dst_i;
   logic                     iss_dbl_i;
   logic                     iss_ready_o;
   logic [4:0]               RSaddr_i;
   logic [4:0]               RTaddr_i;
   logic                     chk_dbl_i;
   logic                     RS_busy_o;
   logic                     RT_busy_o;
   logic [NUM_REQ-1:0]       wb_req_i;
   logic [NUM_REQ-1:0]       wb_gnt_o;
   logic [5*NUM_REQ-1:0]     wb_dst_i;
   logic [NUM_REQ-1:0]       wb_dbl_i;
   logic [64*NUM_REQ-1:0]    wb_data_i;
   logic [NUM_REQ-1:0]       wb_fc_we_i;
   logic [NUM_REQ-1:0]       wb_fc_i;
   logic [1:0]               RegWrite_o;
   logic [4:0]               RDaddr_o;
   logic [31:0]              RDdata_o;
   logic [63:0]              RDdata_D_o;
   logic                     FPcondWrite_o;
   logic                     Fcond_o;

   modport master (
      output iss_valid_i, iss_dst_i, iss_dbl_i, RSaddr_i, RTaddr_i, chk_dbl_i,
             wb_req_i, wb_dst_i, wb_dbl_i, wb_data_i, wb_fc_we_i, wb_fc_i,
      input  iss_ready_o, RS_busy_o, RT_busy_o, wb_gnt_o,
             RegWrite_o, RDaddr_o, RDdata_o, RDdata_D_o, FPcondWrite_o, Fcond_o
   );

   modport slave (
      input  iss_valid_i, iss_dst_i, iss_dbl_i, RSaddr_i, RTaddr_i, chk_dbl_i,
             wb_req_i, wb_dst_i, wb_dbl_i, wb_data_i, wb_fc_we_i, wb_fc_i,
      output iss_ready_o, RS_busy_o, RT_busy_o, wb_gnt_o,
             RegWrite_o, RDaddr_o, RDdata_o, RDdata_D_o, FPcondWrite_o, Fcond_o
   );
endinterface

// File: rtl/fp_wb_scoreboard_arbiter.sv
// FP register-file write-port sequencer: round-robin writeback arbiter plus 32-bit busy scoreboard.
// Optional FP_WB_BYPASS_EN: issue/hazard checks see registers released by this cycle's grant as free.
module fp_wb_scoreboard_arbiter #(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   fp_wb_scoreboard_arbiter_if.slave   bus
);
   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = 32;

   // One-hot of addr, plus addr+1 (5-bit wrap) for doubles
   function automatic logic [31:0] pair_mask(input logic [AW-1:0] a, input logic dbl);
      logic [31:0] m;
      m    = '0;
      m[a] = 1'b1;
      if (dbl) m[a + 5'd1] = 1'b1;
      return m;
   endfunction

   logic [31:0]        busy_q, busy_d, busy_chk, rel_mask, res_mask;
   logic [PW-1:0]      ptr_q, ptr_d, win, idx;
   logic               found, fconly, iss_ready_c;
   logic [NUM_REQ-1:0] gnt_c;
   logic [AW-1:0]      dst_a  [NUM_REQ];
   logic [DW-1:0]      data_a [NUM_REQ];
   logic [AW-1:0]      sel_dst;
   logic [DW-1:0]      sel_data;
   logic               sel_dbl, sel_fc_we, sel_fc;
   logic [1:0]         regwrite_q, regwrite_d;
   logic [AW-1:0]      rdaddr_q, rdaddr_d;
   logic [SW-1:0]      rddata_q, rddata_d;
   logic [DW-1:0]      rddata_dbl_q, rddata_dbl_d;
   logic               fcw_q, fcw_d, fc_q, fc_d;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign dst_a[k]  = bus.wb_dst_i[AW*k +: AW];
      assign data_a[k] = bus.wb_data_i[DW*k +: DW];
   end

   // Round-robin search starting at the pointer
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = PW'((32'(ptr_q) + i) % NUM_REQ);
         if (!found && bus.wb_req_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      gnt_c = '0;
      if (found) gnt_c[win] = 1'b1;
   end

   assign sel_dst   = dst_a[win];
   assign sel_data  = data_a[win];
   assign sel_dbl   = bus.wb_dbl_i[win];
   assign sel_fc_we = bus.wb_fc_we_i[win];
   assign sel_fc    = bus.wb_fc_i[win];
   // Compare-unit result: Fcond only, no register write, scoreboard untouched
   assign fconly    = sel_fc_we & ~sel_dbl & (sel_dst == '0);
   assign rel_mask  = (found && !fconly) ? pair_mask(sel_dst, sel_dbl) : '0;

`ifdef FP_WB_BYPASS_EN
   assign busy_chk = busy_q & ~rel_mask;
`else
   assign busy_chk = busy_q;
`endif

   assign iss_ready_c = ~|(busy_chk & pair_mask(bus.iss_dst_i, bus.iss_dbl_i));
   assign res_mask    = (bus.iss_valid_i && iss_ready_c) ? pair_mask(bus.iss_dst_i, bus.iss_dbl_i) : '0;

   // Next state: release before reserve so a same-edge reserve wins
   always_comb begin
      busy_d       = (busy_q & ~rel_mask) | res_mask;
      ptr_d        = ptr_q;
      regwrite_d   = 2'b00;
      rdaddr_d     = rdaddr_q;
      rddata_d     = rddata_q;
      rddata_dbl_d = rddata_dbl_q;
      fcw_d        = 1'b0;
      fc_d         = fc_q;
      if (found) begin
         ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
         fcw_d = sel_fc_we;
         if (sel_fc_we) fc_d = sel_fc;
         if (!fconly) begin
            regwrite_d = sel_dbl ? 2'b10 : 2'b01;
            rdaddr_d   = sel_dst;
            if (sel_dbl) rddata_dbl_d = sel_data;
            else         rddata_d     = sel_data[SW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= '0;
         ptr_q        <= '0;
         regwrite_q   <= 2'b00;
         rdaddr_q     <= '0;
         rddata_q     <= '0;
         rddata_dbl_q <= '0;
         fcw_q        <= 1'b0;
         fc_q         <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         ptr_q        <= ptr_d;
         regwrite_q   <= regwrite_d;
         rdaddr_q     <= rdaddr_d;
         rddata_q     <= rddata_d;
         rddata_dbl_q <= rddata_dbl_d;
         fcw_q        <= fcw_d;
         fc_q         <= fc_d;
      end
   end

   assign bus.iss_ready_o   = iss_ready_c;
   assign bus.RS_busy_o     = |(busy_chk & pair_mask(bus.RSaddr_i, bus.chk_dbl_i));
   assign bus.RT_busy_o     = |(busy_chk & pair_mask(bus.RTaddr_i, bus.chk_dbl_i));
   assign bus.wb_gnt_o      = rst_n ? gnt_c : '0;
   assign bus.RegWrite_o    = regwrite_q;
   assign bus.RDaddr_o      = rdaddr_q;
   assign bus.RDdata_o      = rddata_q;
   assign bus.RDdata_D_o    = rddata_dbl_q;
   assign bus.FPcondWrite_o = fcw_q;
   assign bus.Fcond_o       = fc_q;
endmodule

// File: tb/tb_fp_wb_scoreboard_arbiter.sv
// Directed plus random bench for fp_wb_scoreboard_arbiter against a per-register scoreboard model.
module tb_fp_wb_scoreboard_arbiter;
   localparam int unsigned N = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp_wb_scoreboard_arbiter_if #(.NUM_REQ(N)) bus ();
   fp_wb_scoreboard_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   bit          busy_m [32];
   int          ptr_m;
   logic [1:0]  e_rw;
   logic [4:0]  e_addr;
   logic [31:0] e_data;
   logic [63:0] e_dd;
   logic        e_fcw, e_fc;
   int          last_w;

   // Per-source request payloads
   bit          req_s  [N];
   logic [4:0]  dst_s  [N];
   bit          dbl_s  [N];
   logic [63:0] data_s [N];
   bit          fcwe_s [N];
   bit          fc_s   [N];

   function automatic int pa(input int a);
      return (a + 1) % 32;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int k = 0; k < int'(N); k++) begin
         bus.wb_req_i[k]          = req_s[k];
         bus.wb_dst_i[5*k +: 5]   = dst_s[k];
         bus.wb_dbl_i[k]          = dbl_s[k];
         bus.wb_data_i[64*k +: 64] = data_s[k];
         bus.wb_fc_we_i[k]        = fcwe_s[k];
         bus.wb_fc_i[k]           = fc_s[k];
      end
   endtask

   task automatic clear_reqs();
      for (int k = 0; k < int'(N); k++) begin
         req_s[k] = 1'b0; dst_s[k] = 5'd0; dbl_s[k] = 1'b0;
         data_s[k] = 64'd0; fcwe_s[k] = 1'b0; fc_s[k] = 1'b0;
      end
      pack();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
      ptr_m = 0; e_rw = 2'b00; e_addr = 5'd0; e_data = 32'd0; e_dd = 64'd0;
      e_fcw = 1'b0; e_fc = 1'b0; last_w = -1;
   endtask

   // Assert reset asynchronously, check cleared outputs at once, release on a falling edge
   task automatic do_reset();
      rst_n = 1'b0;
      bus.wb_req_i = '1;
      #1;
      chk("rst_gnt", 64'(bus.wb_gnt_o), 64'd0);
      chk("rst_regwrite", 64'(bus.RegWrite_o), 64'd0);
      chk("rst_rdaddr", 64'(bus.RDaddr_o), 64'd0);
      chk("rst_rddata", 64'(bus.RDdata_o), 64'd0);
      chk("rst_rddata_d", bus.RDdata_D_o, 64'd0);
      chk("rst_fcw", 64'(bus.FPcondWrite_o), 64'd0);
      chk("rst_fcond", 64'(bus.Fcond_o), 64'd0);
      chk("rst_rs_busy", 64'(bus.RS_busy_o), 64'd0);
      repeat (2) @(negedge clk);
      clear_reqs();
      model_reset();
      rst_n = 1'b1;
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs
   task automatic cycle();
      int          w, d, idx, dst, rsa, rta;
      bit          rel [32];
      bit          view [32];
      bit          rdy, rs, rt, fconly;
      logic [N-1:0] egnt;
      #1;
      w = -1;
      for (int k = 0; k < int'(N); k++) begin
         idx = (ptr_m + k) % int'(N);
         if (req_s[idx] && w < 0) w = idx;
      end
      egnt = '0;
      if (w >= 0) egnt[w] = 1'b1;
      for (int i = 0; i < 32; i++) rel[i] = 1'b0;
      fconly = 1'b0;
      if (w >= 0) begin
         d = int'(dst_s[w]);
         fconly = fcwe_s[w] && !dbl_s[w] && d == 0;
         if (!fconly) begin
            rel[d] = 1'b1;
            if (dbl_s[w]) rel[pa(d)] = 1'b1;
         end
      end
      for (int i = 0; i < 32; i++) begin
`ifdef FP_WB_BYPASS_EN
         view[i] = busy_m[i] && !rel[i];
`else
         view[i] = busy_m[i];
`endif
      end
      dst = int'(bus.iss_dst_i);
      rsa = int'(bus.RSaddr_i);
      rta = int'(bus.RTaddr_i);
      rdy = !view[dst] && !(bus.iss_dbl_i && view[pa(dst)]);
      rs  = view[rsa] || (bus.chk_dbl_i && view[pa(rsa)]);
      rt  = view[rta] || (bus.chk_dbl_i && view[pa(rta)]);
      chk("wb_gnt", 64'(bus.wb_gnt_o), 64'(egnt));
      chk("iss_ready", 64'(bus.iss_ready_o), 64'(rdy));
      chk("rs_busy", 64'(bus.RS_busy_o), 64'(rs));
      chk("rt_busy", 64'(bus.RT_busy_o), 64'(rt));
      for (int i = 0; i < 32; i++) if (rel[i]) busy_m[i] = 1'b0;
      if (bus.iss_valid_i && rdy) begin
         busy_m[dst] = 1'b1;
         if (bus.iss_dbl_i) busy_m[pa(dst)] = 1'b1;
      end
      e_rw = 2'b00; e_fcw = 1'b0;
      if (w >= 0) begin
         ptr_m = (w + 1) % int'(N);
         e_fcw = fcwe_s[w];
         if (fcwe_s[w]) e_fc = fc_s[w];
         if (!fconly) begin
            e_rw   = dbl_s[w] ? 2'b10 : 2'b01;
            e_addr = dst_s[w];
            if (dbl_s[w]) e_dd = data_s[w];
            else          e_data = data_s[w][31:0];
         end
      end
      last_w = w;
      @(posedge clk);
      #1;
      chk("regwrite", 64'(bus.RegWrite_o), 64'(e_rw));
      chk("rdaddr", 64'(bus.RDaddr_o), 64'(e_addr));
      chk("rddata", 64'(bus.RDdata_o), 64'(e_data));
      chk("rddata_d", bus.RDdata_D_o, e_dd);
      chk("fpcondwrite", 64'(bus.FPcondWrite_o), 64'(e_fcw));
      chk("fcond", 64'(bus.Fcond_o), 64'(e_fc));
      @(negedge clk);
   endtask

   task automatic idle_issue();
      bus.iss_valid_i = 1'b0; bus.iss_dst_i = 5'd0; bus.iss_dbl_i = 1'b0;
      bus.RSaddr_i = 5'd0; bus.RTaddr_i = 5'd0; bus.chk_dbl_i = 1'b0;
   endtask

   initial begin
      idle_issue();
      clear_reqs();
      do_reset();

      // Single reserve of f4, then a second issue to f4 is refused
      bus.iss_valid_i = 1'b1; bus.iss_dst_i = 5'd4; bus.RSaddr_i = 5'd4;
      cycle();
      #1 chk("iss4_again", 64'(bus.iss_ready_o), 64'd0);
      chk("rs4_busy", 64'(bus.RS_busy_o), 64'd1);
      cycle();

      // Writeback of f4 from source 0 frees it
      bus.iss_valid_i = 1'b0;
      req_s[0] = 1'b1; dst_s[0] = 5'd4; data_s[0] = 64'hdead_beef_cafe_f00d; pack();
      cycle();
      chk("wb4_regwrite", 64'(bus.RegWrite_o), 64'd1);
      chk("wb4_rdaddr", 64'(bus.RDaddr_o), 64'd4);
      chk("wb4_rddata", 64'(bus.RDdata_o), 64'hcafe_f00d);
      clear_reqs();
      bus.iss_valid_i = 1'b1;
      #1 chk("iss4_after_wb", 64'(bus.iss_ready_o), 64'd1);
      cycle();

      // Double at f31 wraps onto f0
      bus.iss_dst_i = 5'd31; bus.iss_dbl_i = 1'b1;
      cycle();
      idle_issue();
      bus.RTaddr_i = 5'd30;
      #1 chk("rs0_pair31", 64'(bus.RS_busy_o), 64'd1);
      cycle();

      // Reset while a single write is on the output
      req_s[0] = 1'b1; dst_s[0] = 5'd31; data_s[0] = 64'h0123_4567_89ab_cdef; pack();
      cycle();
      chk("pre_rst_regwrite", 64'(bus.RegWrite_o), 64'd1);
      do_reset();
      cycle();

      // All three requesting: round-robin from index 0
      for (int k = 0; k < int'(N); k++) begin
         req_s[k] = 1'b1; dst_s[k] = 5'(k + 1); data_s[k] = {$urandom, $urandom};
      end
      pack();
      for (int i = 0; i < int'(N); i++) begin
         #1 chk("rr_gnt", 64'(bus.wb_gnt_o), 64'(1 << i));
         cycle();
      end
      chk("rr_last_addr", 64'(bus.RDaddr_o), 64'd3);
      clear_reqs();

      // Double writeback from source 1
      bus.iss_valid_i = 1'b1; bus.iss_dst_i = 5'd6; bus.iss_dbl_i = 1'b1;
      cycle();
      idle_issue();
      req_s[1] = 1'b1; dst_s[1] = 5'd6; dbl_s[1] = 1'b1; data_s[1] = 64'h1122_3344_5566_7788; pack();
      cycle();
      chk("dbl_regwrite", 64'(bus.RegWrite_o), 64'd2);
      chk("dbl_rdaddr", 64'(bus.RDaddr_o), 64'd6);
      chk("dbl_data", bus.RDdata_D_o, 64'h1122_3344_5566_7788);
      clear_reqs();
      bus.RSaddr_i = 5'd6; bus.chk_dbl_i = 1'b1;
      #1 chk("dbl_released", 64'(bus.RS_busy_o), 64'd0);
      cycle();

      // Compare result: Fcond only
      idle_issue();
      req_s[2] = 1'b1; fcwe_s[2] = 1'b1; fc_s[2] = 1'b1; pack();
      cycle();
      chk("fc_write", 64'(bus.FPcondWrite_o), 64'd1);
      chk("fc_value", 64'(bus.Fcond_o), 64'd1);
      chk("fc_regwrite", 64'(bus.RegWrite_o), 64'd0);
      clear_reqs();

      // Random traffic; requests held until granted
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < int'(N); k++) begin
            if (!req_s[k] && ($urandom % 3) == 0) begin
               req_s[k]  = 1'b1;
               fcwe_s[k] = ($urandom % 4) == 0;
               fc_s[k]   = 1'($urandom);
               if (fcwe_s[k] && ($urandom % 2) == 0) begin
                  dst_s[k] = 5'd0; dbl_s[k] = 1'b0;
               end else begin
                  dst_s[k] = 5'($urandom); dbl_s[k] = ($urandom % 3) == 0;
               end
               data_s[k] = {$urandom, $urandom};
            end
         end
         pack();
         bus.iss_valid_i = 1'($urandom);
         bus.iss_dst_i   = 5'($urandom);
         bus.iss_dbl_i   = ($urandom % 3) == 0;
         bus.RSaddr_i    = 5'($urandom);
         bus.RTaddr_i    = 5'($urandom);
         bus.chk_dbl_i   = 1'($urandom);
         cycle();
         if (last_w >= 0) req_s[last_w] = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
